aclk_lcd_seq_driver: RTL and testbench

//  Next-generation alarm-clock LCD driver. Selects the key-entry, alarm or current time as
//  a NUM_DIGITS-digit BCD word and converts each digit to ASCII.

---
 rtl/aclk_pkg.sv | 24 ++
 rtl/aclk_digit_to_ascii.sv | 20 ++
 rtl/aclk_lcd_seq_driver.sv | 233 +++++++++++++++++++++++
 tb/tb_aclk_lcd_seq_driver.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aclk_pkg.sv
// Shared definitions for the alarm-clock LCD sequencer:
// ASCII constants, FSM state encoding, digit-index width helper.
package aclk_pkg;

    // ASCII glyphs used by the digit renderer
    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_NINE    = 8'h39;
    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_ERR_DEF = 8'h3A;

    // Frame sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Width of the digit index / screen position
    function automatic int idx_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/aclk_digit_to_ascii.sv
// BCD digit to ASCII renderer; non-decimal codes map to ERR_CHAR.
// Ports: digit_i [3:0] BCD digit in, char_o [7:0] ASCII out.
module aclk_digit_to_ascii
    import aclk_pkg::*;
#(
    parameter logic [7:0] ERR_CHAR = ASCII_ERR_DEF
) (
    input  logic [3:0] digit_i,
    output logic [7:0] char_o
);

    always_comb begin
        char_o = ERR_CHAR;
        unique case (1'b1)
            (digit_i <= 4'd9): char_o = ASCII_ZERO + {4'h0, digit_i};
            (digit_i >  4'd9): char_o = ERR_CHAR;
        endcase
    end

endmodule

// File: rtl/aclk_lcd_seq_driver.sv
// Alarm-clock LCD driver: snapshots the selected BCD time word, streams
// it MS digit first as ASCII over valid/ready, and owns the latched alarm.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   show_a              display alarm time
//   show_new_time       display key entry (wins over show_a)
//   alarm_time          alarm time, BCD, 4*NUM_DIGITS
//   current_time        current time, BCD, 4*NUM_DIGITS
//   key                 key-entry buffer, BCD, 4*NUM_DIGITS
//   alarm_ack           pulse, clears sound_alarm
//   char_ready          LCD controller accepts char
//   char_valid          char_data/char_pos valid
//   char_data [7:0]     ASCII character
//   char_pos            screen position, 0 = leftmost
//   frame_done          pulse after last char accepted
//   sound_alarm         latched alarm indication
// Build option: ACLK_BLINK_EN blanks alternate frames while the alarm sounds.
module aclk_lcd_seq_driver
    import aclk_pkg::*;
#(
    parameter int         NUM_DIGITS  = 4,
    parameter int         REFRESH_DIV = 16,
    parameter logic [7:0] ERR_CHAR    = ASCII_ERR_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             show_a,
    input  logic                             show_new_time,
    input  logic [4*NUM_DIGITS-1:0]          alarm_time,
    input  logic [4*NUM_DIGITS-1:0]          current_time,
    input  logic [4*NUM_DIGITS-1:0]          key,
    input  logic                             alarm_ack,
    input  logic                             char_ready,
    output logic                             char_valid,
    output logic [7:0]                       char_data,
    output logic [idx_width(NUM_DIGITS)-1:0] char_pos,
    output logic                             frame_done,
    output logic                             sound_alarm
);

    localparam int W     = 4 * NUM_DIGITS;
    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV + 1);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     snap_q, snap_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             prev_match_q, prev_match_d;
    logic             sound_q, sound_d;

    logic             accept;
    logic             match;
    logic             fire;
    logic             blank;
    logic [3:0]       digit;
    logic [7:0]       digit_char;

    assign accept = (state_q == ST_SEND) && char_ready;

    // ------------------------------------------------------------
    // State register
    // ------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= CNT_RELOAD;
            snap_q <= '0;
            idx_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
            idx_q  <= idx_d;
        end
    end

    // ------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_LOAD: begin
                // Whole word captured at once so a frame never tears
                unique case (1'b1)
                    show_new_time:
                        snap_d = key;
                    (!show_new_time && show_a):
                        snap_d = alarm_time;
                    (!show_new_time && !show_a):
                        snap_d = current_time;
                endcase
                idx_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            ST_DONE: begin
                cnt_d   = CNT_RELOAD;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------
    // Digit select and render
    // ------------------------------------------------------------
    // Position 0 is the most significant nibble.
    always_comb begin
        digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(NUM_DIGITS - 1 - i)) begin
                digit = snap_q[4*i +: 4];
            end
        end
    end

    aclk_digit_to_ascii #(
        .ERR_CHAR (ERR_CHAR)
    ) u_digit_to_ascii (
        .digit_i (digit),
        .char_o  (digit_char)
    );

    // ------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------
    always_comb begin
        char_valid = 1'b0;
        char_data  = '0;
        char_pos   = '0;
        frame_done = 1'b0;
        unique case (state_q)
            ST_SEND: begin
                char_valid = 1'b1;
                char_data  = blank ? ASCII_SPACE : digit_char;
                char_pos   = idx_q;
            end
            ST_DONE: begin
                frame_done = 1'b1;
            end
            default: begin
                char_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------
    // Alarm latch
    // ------------------------------------------------------------
    // Fires on the rising edge of equality only; prev_match powers
    // up at 1 so equal times out of reset stay silent.
    assign match = (current_time == alarm_time);
    assign fire  = match && !prev_match_q;

    always_comb begin
        prev_match_d = match;
        sound_d      = fire | (sound_q & ~alarm_ack);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_match_q <= 1'b1;
            sound_q      <= 1'b0;
        end else begin
            prev_match_q <= prev_match_d;
            sound_q      <= sound_d;
        end
    end

    assign sound_alarm = sound_q;

    // ------------------------------------------------------------
    // Optional blink
    // ------------------------------------------------------------
`ifdef ACLK_BLINK_EN
    logic blink_q, blink_d;

    // Toggles per frame while sounding, so whole frames alternate.
    always_comb begin
        blink_d = 1'b0;
        if (sound_q) begin
            blink_d = (state_q == ST_DONE) ? ~blink_q : blink_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
        end
    end

    assign blank = blink_q;
`else
    assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_aclk_lcd_seq_driver.sv
// Self-checking bench for aclk_lcd_seq_driver: vector table, hand
// sequences for stall/alarm/reset, randomized frames vs reference model.
module tb_aclk_lcd_seq_driver;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          show_a;
    logic          show_new_time;
    logic [15:0]   alarm_time;
    logic [15:0]   current_time;
    logic [15:0]   key;
    logic          alarm_ack;
    logic          char_ready;
    logic          char_valid;
    logic [7:0]    char_data;
    logic [PW-1:0] char_pos;
    logic          frame_done;
    logic          sound_alarm;

    aclk_lcd_seq_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .show_a        (show_a),
        .show_new_time (show_new_time),
        .alarm_time    (alarm_time),
        .current_time  (current_time),
        .key           (key),
        .alarm_ack     (alarm_ack),
        .char_ready    (char_ready),
        .char_valid    (char_valid),
        .char_data     (char_data),
        .char_pos      (char_pos),
        .frame_done    (frame_done),
        .sound_alarm   (sound_alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          sn;
        bit          sa;
        logic [15:0] k;
        logic [15:0] a;
        logic [15:0] c;
        logic [31:0] chars;
    } vec_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc_n = 0;
    int          got_d[$];
    int          got_p[$];
    bit          got_b[$];
    logic [31:0] exp_chars;
    bit          exp_armed;
    bit          frame_seen;
    bit          mon_en;
    bit          stall_q;
    logic [7:0]  stall_d;
    logic [PW-1:0] stall_p;
    bit          m_prev;
    bit          m_sound;
    bit          m_blink;
    bit          in_eq;
    bit          in_ack;
    bit          rnd_ready;
    bit          rnd_ack;
    vec_t        tbl[7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: digit at screen position pos of a BCD word, as ASCII
    function automatic logic [7:0] ref_char(input logic [15:0] w,
                                            input int pos);
        int d;
        d = (int'(w) / (16 ** (ND - 1 - pos))) % 16;
        return (d <= 9) ? 8'(48 + d) : 8'h3A;
    endfunction

    function automatic logic [31:0] ref_frame(input bit sn, input bit sa,
        input logic [15:0] k, input logic [15:0] a, input logic [15:0] c);
        logic [15:0] w;
        logic [31:0] r;
        w = sn ? k : (sa ? a : c);
        r = '0;
        for (int i = 0; i < ND; i++) r = {r[23:0], ref_char(w, i)};
        return r;
    endfunction

    task automatic monitor();
        logic [7:0] e;
        check("sound_alarm", sound_alarm, m_sound);
        if (stall_q) begin
            check("hold_valid", char_valid, 1);
            check("hold_data", char_data, stall_d);
            check("hold_pos", char_pos, stall_p);
        end
        stall_q = char_valid && !char_ready;
        stall_d = char_data;
        stall_p = char_pos;
        if (char_valid && char_ready) begin
            got_d.push_back(int'(char_data));
            got_p.push_back(int'(char_pos));
            got_b.push_back(m_blink);
        end
        if (frame_done) begin
            frame_seen = 1;
            if (exp_armed) begin
                check("frame_len", got_d.size(), ND);
                for (int i = 0; i < got_d.size() && i < ND; i++) begin
                    e = 8'(exp_chars >> (8 * (ND - 1 - i)));
                    if (got_b[i]) e = 8'h20;
                    check("char_pos", got_p[i], i);
                    check("char_data", got_d[i], e);
                end
                exp_armed = 0;
            end
            got_d.delete();
            got_p.delete();
            got_b.delete();
        end
`ifdef ACLK_BLINK_EN
        m_blink = m_sound && (frame_done ? !m_blink : m_blink);
`endif
    endtask

    // One clock: observe at negedge, advance alarm model at posedge,
    // return 1 time unit after the edge for the caller to drive.
    task automatic cyc();
        @(negedge clk);
        if (mon_en) monitor();
        in_eq  = (current_time == alarm_time);
        in_ack = alarm_ack;
        @(posedge clk);
        if (mon_en) begin
            if (in_eq && !m_prev) m_sound = 1;
            else if (in_ack) m_sound = 0;
            m_prev = in_eq;
        end
        #1;
        cyc_n++;
    endtask

    task automatic arm(input logic [31:0] chars);
        exp_chars  = chars;
        exp_armed  = 1;
        frame_seen = 0;
    endtask

    task automatic wait_done();
        frame_seen = 0;
        for (int n = 0; n < 300 && !frame_seen; n++) begin
            cyc();
            if (rnd_ready) char_ready = ($urandom_range(0, 3) != 0);
            if (rnd_ack) alarm_ack = ($urandom_range(0, 15) == 0);
        end
        check("frame_timeout", frame_seen, 1);
    endtask

    task automatic run_frame(input logic [31:0] chars);
        arm(chars);
        wait_done();
    endtask

    task automatic release_reset();
        got_d.delete();
        got_p.delete();
        got_b.delete();
        stall_q   = 0;
        exp_armed = 0;
        m_prev    = 1;
        m_sound   = 0;
        m_blink   = 0;
        rst_n     = 1;
        mon_en    = 1;
    endtask

    initial begin
        int c0;
        int n;
        tbl[0] = '{0, 0, 16'h0000, 16'h1234, 16'h1259, 32'h31323539};
        tbl[1] = '{1, 1, 16'h0A07, 16'h1234, 16'h1259, 32'h303A3037};
        tbl[2] = '{0, 1, 16'h0A07, 16'h0930, 16'h1259, 32'h30393330};
        tbl[3] = '{0, 0, 16'h0A07, 16'h0930, 16'hFFFF, 32'h3A3A3A3A};
        tbl[4] = '{1, 0, 16'h0000, 16'h0930, 16'hFFFF, 32'h30303030};
        tbl[5] = '{0, 0, 16'h0000, 16'h0930, 16'h9B05, 32'h393A3035};
        tbl[6] = '{0, 1, 16'h0000, 16'h2359, 16'h1234, 32'h32333539};

        rst_n = 0;
        show_a = 0;
        show_new_time = 0;
        key = 16'h0000;
        alarm_time = 16'h1234;
        current_time = 16'h1259;
        alarm_ack = 0;
        char_ready = 1;
        mon_en = 0;
        rnd_ready = 0;
        rnd_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", char_valid, 0);
        check("rst_data", char_data, 0);
        check("rst_pos", char_pos, 0);
        check("rst_done", frame_done, 0);
        check("rst_sound", sound_alarm, 0);

        // Vector table: inputs set while idle, checked on the next frame
        release_reset();
        foreach (tbl[i]) begin
            show_new_time = tbl[i].sn;
            show_a        = tbl[i].sa;
            key           = tbl[i].k;
            alarm_time    = tbl[i].a;
            current_time  = tbl[i].c;
            run_frame(tbl[i].chars);
        end

        // Frame period with ready tied high
        c0 = cyc_n;
        run_frame(32'h32333539);
        check("frame_period", cyc_n - c0, RD + ND + 2);

        // Stall at pos 1; time change mid-frame must not leak in
        show_a = 0;
        alarm_time = 16'h0930;
        current_time = 16'h1259;
        arm(32'h31323539);
        for (n = 0; n < 50 && !(char_valid && char_pos == 1); n++) cyc();
        check("found_pos1", char_valid && char_pos == 1, 1);
        char_ready = 0;
        current_time = 16'h0000;
        repeat (5) cyc();
        char_ready = 1;
        wait_done();
        run_frame(32'h30303030);

        // Alarm set / ack / no refire / set wins over ack
        alarm_time = 16'h0700;
        current_time = 16'h0659;
        repeat (2) cyc();
        current_time = 16'h0700;
        check("alarm_pre", sound_alarm, 0);
        cyc();
        check("alarm_set", sound_alarm, 1);
        alarm_ack = 1;
        cyc();
        alarm_ack = 0;
        check("alarm_ack", sound_alarm, 0);
        repeat (5) cyc();
        check("alarm_no_refire", sound_alarm, 0);
        current_time = 16'h0659;
        cyc();
        current_time = 16'h0700;
        alarm_ack = 1;
        cyc();
        alarm_ack = 0;
        check("alarm_set_wins", sound_alarm, 1);
        wait_done();
        run_frame(32'h30373030);
        run_frame(32'h30373030);
        alarm_ack = 1;
        cyc();
        alarm_ack = 0;
        wait_done();

        // Randomized frames against the reference model
        rnd_ready = 1;
        rnd_ack = 1;
        for (int f = 0; f < 25; f++) begin
            show_new_time = 1'($urandom_range(0, 1));
            show_a        = 1'($urandom_range(0, 1));
            key           = 16'($urandom);
            alarm_time    = 16'($urandom);
            current_time  = ($urandom_range(0, 2) == 0) ?
                            alarm_time : 16'($urandom);
            run_frame(ref_frame(show_new_time, show_a, key,
                                alarm_time, current_time));
        end
        rnd_ready = 0;
        rnd_ack = 0;
        char_ready = 1;
        alarm_ack = 0;

        // Reset mid-frame at pos 2
        show_new_time = 0;
        show_a = 0;
        for (n = 0; n < 50 && !(char_valid && char_pos == 2); n++) cyc();
        check("found_pos2", char_valid && char_pos == 2, 1);
        #2;
        mon_en = 0;
        rst_n = 0;
        #1;
        check("arst_valid", char_valid, 0);
        check("arst_data", char_data, 0);
        check("arst_pos", char_pos, 0);
        check("arst_done", frame_done, 0);
        check("arst_sound", sound_alarm, 0);
        current_time = 16'h1234;
        alarm_time = 16'h1234;
        repeat (2) @(posedge clk);
        #1;
        release_reset();
        arm(32'h31323334);
        for (n = 0; n < 50 && !char_valid; n++) cyc();
        check("first_char_latency", n, RD + 1);
        check("first_char_pos", char_pos, 0);
        wait_done();
        check("no_alarm_at_reset", sound_alarm, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
